// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: word width, reset/bubble
// defaults, next-PC selection encoding and the IF/ID register payload.
package fetch_stage_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam word_t DEFAULT_NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
    localparam word_t PC_STEP           = 32'h0000_0004;

    // Source of the PC value loaded at the next edge
    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_HOLD   = 2'd1,
        PC_BRANCH = 2'd2,
        PC_JUMP   = 2'd3
    } pc_sel_t;

    // Contents of the IF/ID pipeline register
    typedef struct packed {
        word_t instr;
        word_t pc_plus4;
        logic  valid;
    } ifid_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Bubble has priority over hold so a squash request
// still clears the register while the PC is frozen.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter word_t NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  hold,
    input  logic  bubble,
    input  word_t next_instr,
    input  word_t next_pc_plus4,
    output word_t ifid_instr,
    output word_t ifid_pc_plus4,
    output logic  ifid_valid
);

    ifid_t ifid_r;
    ifid_t bubble_s;

    // Bubble payload: NOP with no associated PC
    always_comb begin
        bubble_s.instr    = NOP_INSTR;
        bubble_s.pc_plus4 = 32'h0000_0000;
        bubble_s.valid    = 1'b0;
    end

    // Register update: reset, bubble, hold, or capture the fetched word
    always_ff @(posedge clk) begin
        if (!reset) begin
            ifid_r <= bubble_s;
        end else if (bubble) begin
            ifid_r <= bubble_s;
        end else if (hold) begin
            ifid_r <= ifid_r;
        end else begin
            ifid_r.instr    <= next_instr;
            ifid_r.pc_plus4 <= next_pc_plus4;
            ifid_r.valid    <= 1'b1;
        end
    end

    assign ifid_instr    = ifid_r.instr;
    assign ifid_pc_plus4 = ifid_r.pc_plus4;
    assign ifid_valid    = ifid_r.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC priority (jump > branch >
// stall > sequential), fetched-instruction counter and the IF/ID register.
// imemAddr and pcPlus4 depend only on the PC register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter word_t RESET_PC  = DEFAULT_RESET_PC,
    parameter word_t NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic        jump,
    input  logic [31:0] jumpTarget,
    input  logic [31:0] imemRdata,
    output logic [31:0] imemAddr,
    output logic [31:0] pcPlus4,
    output logic [31:0] ifidInstr,
    output logic [31:0] ifidPcPlus4,
    output logic        ifidValid,
    output logic [31:0] fetchCount
);

    word_t   pc_r;
    word_t   pc_next_s;
    word_t   pc_plus4_s;
    word_t   fetch_count_r;
    pc_sel_t pc_sel_s;
    logic    redirect_s;
    logic    ifid_bubble_s;
    logic    ifid_hold_s;
    logic    ifid_load_s;

    assign pc_plus4_s = pc_r + PC_STEP;
    assign redirect_s = jump | branchTaken;

    // Next-PC source; a redirect overrides stall, jump beats branch
    always_comb begin
        pc_sel_s = PC_SEQ;
        if (jump) begin
            pc_sel_s = PC_JUMP;
        end else if (branchTaken) begin
            pc_sel_s = PC_BRANCH;
        end else if (stall) begin
            pc_sel_s = PC_HOLD;
        end else begin
            pc_sel_s = PC_SEQ;
        end
    end

    // Next-PC value mux
    always_comb begin
        pc_next_s = pc_plus4_s;
        case (pc_sel_s)
            PC_SEQ:    pc_next_s = pc_plus4_s;
            PC_HOLD:   pc_next_s = pc_r;
            PC_BRANCH: pc_next_s = branchTarget;
            PC_JUMP:   pc_next_s = jumpTarget;
            default:   pc_next_s = pc_plus4_s;
        endcase
    end

    // IF/ID controls: redirect or flush squash, stall alone holds, else load
    always_comb begin
        ifid_bubble_s = redirect_s | flush;
        ifid_hold_s   = 1'b0;
        ifid_load_s   = 1'b0;
        if (ifid_bubble_s) begin
            ifid_hold_s = 1'b0;
            ifid_load_s = 1'b0;
        end else if (stall) begin
            ifid_hold_s = 1'b1;
            ifid_load_s = 1'b0;
        end else begin
            ifid_hold_s = 1'b0;
            ifid_load_s = 1'b1;
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // Count of real instructions loaded into IF/ID, wraps silently
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_count_r <= 32'h0000_0000;
        end else if (ifid_load_s) begin
            fetch_count_r <= fetch_count_r + 32'h0000_0001;
        end else begin
            fetch_count_r <= fetch_count_r;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk           (clk),
        .reset         (reset),
        .hold          (ifid_hold_s),
        .bubble        (ifid_bubble_s),
        .next_instr    (imemRdata),
        .next_pc_plus4 (pc_plus4_s),
        .ifid_instr    (ifidInstr),
        .ifid_pc_plus4 (ifidPcPlus4),
        .ifid_valid    (ifidValid)
    );

    assign imemAddr   = pc_r;
    assign pcPlus4    = pc_plus4_s;
    assign fetchCount = fetch_count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        jump;
    logic [31:0] jumpTarget;
    logic [31:0] imemRdata;
    logic [31:0] imemAddr;
    logic [31:0] pcPlus4;
    logic [31:0] ifidInstr;
    logic [31:0] ifidPcPlus4;
    logic        ifidValid;
    logic [31:0] fetchCount;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pp4;
    logic        m_valid;
    logic [31:0] m_cnt;

    fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .jump         (jump),
        .jumpTarget   (jumpTarget),
        .imemRdata    (imemRdata),
        .imemAddr     (imemAddr),
        .pcPlus4      (pcPlus4),
        .ifidInstr    (ifidInstr),
        .ifidPcPlus4  (ifidPcPlus4),
        .ifidValid    (ifidValid),
        .fetchCount   (fetchCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Compare every output against the model
    task automatic check_all(input string tag);
        check_eq({tag, "_addr"},  imemAddr,  m_pc);
        check_eq({tag, "_pp4"},   pcPlus4,   m_pc + 32'd4);
        check_eq({tag, "_valid"}, {31'd0, ifidValid}, {31'd0, m_valid});
        check_eq({tag, "_instr"}, ifidInstr, m_instr);
        if (m_valid) check_eq({tag, "_ifpp4"}, ifidPcPlus4, m_pp4);
        check_eq({tag, "_cnt"},   fetchCount, m_cnt);
    endtask

    // Apply one cycle of inputs (called just after a negedge), advance the
    // model by the documented priority rules, then check after the edge.
    task automatic cyc(input logic rst, input logic st, input logic fl,
                       input logic br, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt,
                       input logic [31:0] rd, input string tag);
        reset = rst; stall = st; flush = fl;
        branchTaken = br; branchTarget = bt; jump = j; jumpTarget = jt;
        imemRdata = rd;
        if (!rst) begin
            m_pc = RESET_PC; m_instr = NOP_INSTR; m_pp4 = 32'd0; m_valid = 1'b0; m_cnt = 32'd0;
        end else if (j || br) begin
            m_pc = j ? jt : bt;
            m_instr = NOP_INSTR; m_valid = 1'b0;
        end else if (st) begin
            if (fl) begin
                m_instr = NOP_INSTR; m_valid = 1'b0;
            end
        end else if (fl) begin
            m_instr = NOP_INSTR; m_valid = 1'b0;
            m_pc = m_pc + 32'd4;
        end else begin
            m_instr = rd; m_pp4 = m_pc + 32'd4; m_valid = 1'b1;
            m_cnt = m_cnt + 32'd1;
            m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic seq(input int n, input string tag);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, $urandom, tag);
    endtask

    task automatic do_reset(input string tag);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, tag);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, tag);
    endtask

    initial begin
        logic st, fl, br, j, rst;
        reset = 1'b0; stall = 1'b0; flush = 1'b0; branchTaken = 1'b0;
        branchTarget = 32'd0; jump = 1'b0; jumpTarget = 32'd0; imemRdata = 32'd0;
        m_pc = RESET_PC; m_instr = NOP_INSTR; m_pp4 = 32'd0; m_valid = 1'b0; m_cnt = 32'd0;

        // 1: reset then first fetch
        do_reset("t1_rst");
        check_eq("t1_addr0", imemAddr, 32'h0000_0000);
        check_eq("t1_valid0", {31'd0, ifidValid}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'h2008_0005, "t1");
        check_eq("t1_instr", ifidInstr, 32'h2008_0005);
        check_eq("t1_ifpp4", ifidPcPlus4, 32'd4);
        check_eq("t1_cnt", fetchCount, 32'd1);
        check_eq("t1_addr", imemAddr, 32'd4);

        // 2: four sequential fetches from 0
        do_reset("t2_rst");
        seq(4, "t2");
        check_eq("t2_addr", imemAddr, 32'd16);
        check_eq("t2_cnt", fetchCount, 32'd4);

        // 3: stall three cycles at PC 8, then release
        do_reset("t3_rst");
        seq(2, "t3_pre");
        for (int k = 0; k < 3; k++)
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, $urandom, "t3_stall");
        check_eq("t3_hold_addr", imemAddr, 32'd8);
        check_eq("t3_hold_cnt", fetchCount, 32'd2);
        seq(1, "t3_rel");
        check_eq("t3_resume", imemAddr, 32'd12);

        // 4: taken branch in a stall cycle redirects anyway
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'd0, $urandom, "t4");
        check_eq("t4_addr", imemAddr, 32'h40);
        check_eq("t4_valid", {31'd0, ifidValid}, 32'd0);
        check_eq("t4_instr", ifidInstr, NOP_INSTR);
        check_eq("t4_cnt", fetchCount, 32'd3);

        // 5: jump beats branch; flush alone at PC 16
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h0040_0000, $urandom, "t5_jb");
        check_eq("t5_jump", imemAddr, 32'h0040_0000);
        do_reset("t5_rst");
        seq(4, "t5_pre");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, $urandom, "t5_flush");
        check_eq("t5_faddr", imemAddr, 32'd20);
        check_eq("t5_fvalid", {31'd0, ifidValid}, 32'd0);

        // 6: PC wrap, then reset with a jump pending
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, $urandom, "t6_j");
        seq(1, "t6_wrap");
        check_eq("t6_wrap_addr", imemAddr, 32'h0000_0000);
        check_eq("t6_wrap_ifpp4", ifidPcPlus4, 32'h0000_0000);
        seq(3, "t6_more");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h1234_5678, $urandom, "t6_rst");
        check_eq("t6_rst_addr", imemAddr, RESET_PC);
        check_eq("t6_rst_cnt", fetchCount, 32'd0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) != 0);
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 5) == 0);
            br  = ($urandom_range(0, 7) == 0);
            j   = ($urandom_range(0, 9) == 0);
            cyc(rst, st, fl, br, $urandom, j, $urandom, $urandom, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
